// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the TX FIFO, loads the holding register and
// serialises start, 8 data bits LSB-first, optional parity and 1/2 stop bits.
module uart_tx_ctrl #(
    parameter int unsigned OVS = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_tick_i,
    input  logic       tx_en_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       stop2_i,
    input  logic       fifo_empty_i,
    output logic       fifo_rd_o,
    output logic       hold_en_o,
    input  logic [7:0] hold_q_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] TICK_LAST = 5'(OVS - 1);

    state_t     state;
    logic [4:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;
    logic       first;
    logic       par_en_sh;
    logic       par_odd_sh;
    logic       stop2_sh;
    logic       bit_end;

    assign bit_end = baud_tick_i && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            first      <= 1'b0;
            par_en_sh  <= 1'b0;
            par_odd_sh <= 1'b0;
            stop2_sh   <= 1'b0;
            fifo_rd_o  <= 1'b0;
            hold_en_o  <= 1'b0;
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            fifo_rd_o <= 1'b0;
            hold_en_o <= 1'b0;
            done_o    <= 1'b0;

            if ((state inside {START, DATA, PARITY, STOP}) && baud_tick_i)
                tick_cnt <= bit_end ? '0 : tick_cnt + 5'd1;

            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    // A pop issued on the previous cycle (or on the done cycle) commits the frame.
                    if (fifo_rd_o) begin
                        state     <= LOAD;
                        hold_en_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end else if (tx_en_i && !fifo_empty_i) begin
                        fifo_rd_o <= 1'b1;
                    end
                end
                LOAD: begin
                    par_en_sh  <= parity_en_i;
                    par_odd_sh <= parity_odd_i;
                    stop2_sh   <= stop2_i;
                    tick_cnt   <= '0;
                    bit_cnt    <= '0;
                    first      <= 1'b1;
                    tx_o       <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (first) begin
                        shreg   <= hold_q_i;
                        par_bit <= (^hold_q_i) ^ par_odd_sh;
                        first   <= 1'b0;
                    end
                    if (bit_end) begin
                        tx_o  <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (par_en_sh) begin
                                tx_o  <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx_o  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx_o    <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_o  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop2_sh && (bit_cnt == 3'd0)) begin
                            bit_cnt <= 3'd1;
                        end else begin
                            bit_cnt   <= '0;
                            state     <= IDLE;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                            fifo_rd_o <= tx_en_i && !fifo_empty_i;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: FIFO and holding-register models plus a
// line-level frame checker derived from bit-period rules, with random baud ticks.
module tb_uart_tx_ctrl;

    localparam int unsigned OVS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick = 1'b0;
    logic       tx_en;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
    logic       fifo_empty;
    logic       fifo_rd;
    logic       hold_en;
    logic [7:0] hold_q = '0;
    logic [7:0] fifo_data = '0;
    logic       tx;
    logic       busy;
    logic       done;

    logic       tick_on = 1'b0;
    logic [7:0] mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    int         rd_count = 0;
    int         hold_count = 0;
    int         done_count = 0;
    int         last_done_cyc = 0;
    int         checks = 0;
    int         errors = 0;

    uart_tx_ctrl #(.OVS(OVS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .baud_tick_i  (baud_tick),
        .tx_en_i      (tx_en),
        .parity_en_i  (par_en),
        .parity_odd_i (par_odd),
        .stop2_i      (stop2),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd),
        .hold_en_o    (hold_en),
        .hold_q_i     (hold_q),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        baud_tick = tick_on && ($urandom_range(0, 1) == 1);
    end

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) rd_count <= rd_count + 1;
        if (hold_en) hold_count <= hold_count + 1;
        if (done) done_count <= done_count + 1;
        if (fifo_rd && (rd_ptr != wr_ptr)) begin
            fifo_data <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
        if (hold_en) hold_q <= fifo_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    // Expects one frame of byte d: each line bit lasts exactly OVS counted ticks,
    // the line moves on the cycle after the OVS-th tick, done follows the last stop bit.
    task automatic run_frame(input logic [7:0] d, input logic p, input logic odd,
                             input logic s2, input logic gap);
        logic exp_bits [12];
        int   n;
        int   bad;
        int   ticks;
        int   guard;
        for (int i = 0; i < 4000 && fifo_rd !== 1'b1; i++) @(negedge clk);
        chk("rd_pulse", fifo_rd, 1);
        if (gap) chk("b2b_rd_on_done", cyc, last_done_cyc);
        @(negedge clk);
        chk("hold_en", hold_en, 1);
        chk("busy_load", busy, 1);
        chk("gap_high", tx, 1);
        @(negedge clk);
        n = 0;
        exp_bits[n++] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[n++] = d[i];
        if (p) exp_bits[n++] = (^d) ^ odd;
        exp_bits[n++] = 1'b1;
        if (s2) exp_bits[n++] = 1'b1;
        for (int b = 0; b < n; b++) begin
            bad = 0;
            ticks = 0;
            guard = 0;
            while (1) begin
                if (tx !== exp_bits[b] || done !== 1'b0 || busy !== 1'b1) bad++;
                if (baud_tick) ticks++;
                if (ticks == OVS || guard > 2000) break;
                guard++;
                @(negedge clk);
            end
            @(negedge clk);
            chk($sformatf("frame_%02h_bit%0d", d, b), bad, 0);
        end
        chk("done", done, 1);
        chk("idle_tx", tx, 1);
        chk("busy_idle", busy, 0);
        last_done_cyc = cyc;
    endtask

    initial begin
        int r0, h0, d0;
        logic [7:0] rb;
        rst_n = 1'b0; tx_en = 1'b0; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        tick_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_hold", hold_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // enable gating
        rst_n = 1'b1;
        push(8'h55);
        repeat (60) @(negedge clk);
        chk("gate_no_rd", rd_count, 0);
        chk("gate_tx", tx, 1);
        chk("gate_busy", busy, 0);

        // single byte, no parity, one stop
        r0 = rd_count; h0 = hold_count; d0 = done_count;
        tx_en = 1'b1;
        run_frame(8'h55, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("single_rd_cnt", rd_count - r0, 1);
        chk("single_hold_cnt", hold_count - h0, 1);
        chk("single_done_cnt", done_count - d0, 1);

        // parity with two stop bits
        par_en = 1'b1; stop2 = 1'b1; par_odd = 1'b0;
        push(8'h03);
        run_frame(8'h03, 1, 0, 1, 0);
        par_odd = 1'b1;
        push(8'h03);
        run_frame(8'h03, 1, 1, 1, 0);

        // back-to-back frames
        par_en = 1'b0; stop2 = 1'b0; par_odd = 1'b0;
        push(8'hA5);
        push(8'h0F);
        run_frame(8'hA5, 0, 0, 0, 0);
        run_frame(8'h0F, 0, 0, 0, 1);

        // random bytes and configurations
        for (int k = 0; k < 4; k++) begin
            par_en  = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            stop2   = 1'($urandom_range(0, 1));
            rb      = 8'($urandom_range(0, 255));
            push(rb);
            run_frame(rb, par_en, par_odd, stop2, 0);
        end

        // config shadowing: parity enabled mid-frame applies to the next frame
        par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        push(8'h6C);
        push(8'h91);
        fork
            run_frame(8'h6C, 0, 0, 0, 0);
            begin
                repeat (100) @(negedge clk);
                par_en = 1'b1;
            end
        join
        run_frame(8'h91, 1, 0, 0, 1);

        // tx_en dropped during data: frame completes, no further pop
        par_en = 1'b0;
        repeat (5) @(negedge clk);
        r0 = rd_count;
        push(8'hE2);
        push(8'h37);
        fork
            run_frame(8'hE2, 0, 0, 0, 0);
            begin
                for (int i = 0; i < 4000 && tx !== 1'b0; i++) @(negedge clk);
                repeat (60) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        repeat (100) @(negedge clk);
        chk("drop_rd_cnt", rd_count - r0, 1);
        chk("drop_tx", tx, 1);
        chk("drop_busy", busy, 0);

        // reset during data bit 3 of 0x37, then 0xC4 sent cleanly
        push(8'hC4);
        tx_en = 1'b1;
        for (int i = 0; i < 200 && tx !== 1'b0; i++) @(negedge clk);
        chk("rst_frame_start", tx, 0);
        r0 = 0;
        for (int i = 0; i < 4000 && r0 < 70; i++) begin
            if (baud_tick) r0++;
            @(negedge clk);
        end
        chk("pre_reset_bit3", tx, 0);
        d0 = done_count;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_done", done_count - d0, 0);
        run_frame(8'hC4, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
